// File: rtl/sync_fifo_mc.sv
// Single-clock multi-channel FIFO. NCH independent queues of 2**ASIZE words
// share one storage array; channel c word i lives at address {c,i}.
// Per-channel flags and levels are registered from the next-state level.
// FALLTHROUGH="TRUE" presents the selected channel's head word combinationally;
// "FALSE" registers the popped word and pulses rvalid for one cycle.

module sync_fifo_mc #(
    parameter int DSIZE       = 8,
    parameter int ASIZE       = 4,
    parameter int NCH         = 4,
    parameter     FALLTHROUGH = "TRUE",
    parameter int AWFULL_GAP  = 1,
    parameter int AREMPTY_GAP = 1,
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     winc,
    input  logic [CW-1:0]            wch,
    input  logic [DSIZE-1:0]         wdata,
    input  logic                     rinc,
    input  logic [CW-1:0]            rch,
    output logic [DSIZE-1:0]         rdata,
    output logic                     rvalid,
    output logic [NCH-1:0]           wfull,
    output logic [NCH-1:0]           awfull,
    output logic [NCH-1:0]           rempty,
    output logic [NCH-1:0]           arempty,
    output logic [NCH*(ASIZE+1)-1:0] level,
    output logic                     wovf,
    output logic                     rudf
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int LW    = ASIZE + 1;
    localparam int MW    = CW + ASIZE;
    localparam bit FWFT  = (FALLTHROUGH == "TRUE");

    localparam logic [CW:0]    NCH_L   = (CW+1)'(NCH);
    localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0]  AF_L    = LW'(DEPTH - AWFULL_GAP);
    localparam logic [LW-1:0]  AE_L    = LW'(AREMPTY_GAP);

    logic [DSIZE-1:0] mem [NCH*DEPTH];

    logic [ASIZE-1:0] wptr    [NCH];
    logic [ASIZE-1:0] rptr    [NCH];
    logic [LW-1:0]    lvl     [NCH];
    logic [LW-1:0]    lvl_nxt [NCH];

    logic          wch_ok;
    logic          rch_ok;
    logic          w_acc;
    logic          r_acc;
    logic [MW-1:0] waddr;
    logic [MW-1:0] raddr;

    // Channel selects beyond NCH (non-power-of-2 channel counts) never hit a queue.
    assign wch_ok = ({1'b0, wch} < NCH_L);
    assign rch_ok = ({1'b0, rch} < NCH_L);

    // Accept decisions use only pre-edge flags, so a full channel rejects a write
    // even while it is being read, and an empty one rejects a read while written.
    assign w_acc = winc && wch_ok && !wfull[wch];
    assign r_acc = rinc && rch_ok && !rempty[rch];

    assign waddr = {wch, wptr[wch]};
    assign raddr = {rch, rptr[rch]};

    // Next-state occupancy: a same-channel push and pop cancel out.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            lvl_nxt[c] = lvl[c];
            if (w_acc && (wch == CW'(c)) && !(r_acc && (rch == CW'(c))))
                lvl_nxt[c] = lvl[c] + LW'(1);
            else if (r_acc && (rch == CW'(c)) && !(w_acc && (wch == CW'(c))))
                lvl_nxt[c] = lvl[c] - LW'(1);
        end
    end

    // Pointers, levels, flags and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                lvl[c]  <= '0;
            end
            wfull   <= '0;
            awfull  <= '0;
            rempty  <= '1;
            arempty <= '1;
            wovf    <= 1'b0;
            rudf    <= 1'b0;
        end else begin
            if (w_acc)
                wptr[wch] <= wptr[wch] + ASIZE'(1);
            if (r_acc)
                rptr[rch] <= rptr[rch] + ASIZE'(1);
            for (int c = 0; c < NCH; c++) begin
                lvl[c]     <= lvl_nxt[c];
                wfull[c]   <= (lvl_nxt[c] == DEPTH_L);
                awfull[c]  <= (lvl_nxt[c] >= AF_L);
                rempty[c]  <= (lvl_nxt[c] == '0);
                arempty[c] <= (lvl_nxt[c] <= AE_L);
            end
            wovf <= winc && !w_acc;
            rudf <= rinc && !r_acc;
        end
    end

    // Shared storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_acc)
            mem[waddr] <= wdata;
    end

    genvar g;
    for (g = 0; g < NCH; g++) begin : g_lvl
        assign level[g*LW +: LW] = lvl[g];
    end

    if (FWFT) begin : g_fwft
        // Head word of the selected channel, visible one edge after it was written.
        assign rdata  = mem[raddr];
        assign rvalid = rch_ok && !rempty[rch];
    end else begin : g_reg
        logic [DSIZE-1:0] rdata_q;
        logic             rvalid_q;

        // Popped word is captured at the accepting edge and held until the next pop.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= r_acc;
                if (r_acc)
                    rdata_q <= mem[raddr];
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_sync_fifo_mc.sv
// Bench for sync_fifo_mc: one fall-through and one registered-read instance
// share the same stimulus; a queue-per-channel reference model supplies all
// expected flags, levels, error pulses and read data.

module tb_sync_fifo_mc;

    localparam int NCH = 4;
    localparam int DEP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic [1:0] wch;
    logic [7:0] wdata;
    logic       rinc;
    logic [1:0] rch;

    logic [7:0]  rdata_f, rdata_r;
    logic        rvalid_f, rvalid_r;
    logic [3:0]  wfull_f, awfull_f, rempty_f, arempty_f;
    logic [3:0]  wfull_r, awfull_r, rempty_r, arempty_r;
    logic [19:0] level_f, level_r;
    logic        wovf_f, rudf_f, wovf_r, rudf_r;

    sync_fifo_mc dut_f (
        .clk(clk), .rst(rst), .winc(winc), .wch(wch), .wdata(wdata),
        .rinc(rinc), .rch(rch), .rdata(rdata_f), .rvalid(rvalid_f),
        .wfull(wfull_f), .awfull(awfull_f), .rempty(rempty_f), .arempty(arempty_f),
        .level(level_f), .wovf(wovf_f), .rudf(rudf_f)
    );

    sync_fifo_mc #(.FALLTHROUGH("FALSE")) dut_r (
        .clk(clk), .rst(rst), .winc(winc), .wch(wch), .wdata(wdata),
        .rinc(rinc), .rch(rch), .rdata(rdata_r), .rvalid(rvalid_r),
        .wfull(wfull_r), .awfull(awfull_r), .rempty(rempty_r), .arempty(arempty_r),
        .level(level_r), .wovf(wovf_r), .rudf(rudf_r)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq [NCH][$];
    logic [7:0] exp_f [$];
    logic [7:0] exp_r [$];
    logic       exp_wovf = 1'b0;
    logic       exp_rudf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input bit w, input int wc, input logic [7:0] wd,
                        input bit r, input int rc);
        bit w_acc, r_acc;
        logic [7:0] head;
        winc  = w;
        wch   = 2'(wc);
        wdata = wd;
        rinc  = r;
        rch   = 2'(rc);
        w_acc = w && (mq[wc].size() < DEP);
        r_acc = r && (mq[rc].size() > 0);
        head  = r_acc ? mq[rc][0] : 8'h00;
        if (r_acc) exp_f.push_back(head);
        @(posedge clk);
        if (r_acc) begin
            void'(mq[rc].pop_front());
            exp_r.push_back(head);
        end
        if (w_acc) mq[wc].push_back(wd);
        exp_wovf = w && !w_acc;
        exp_rudf = r && !r_acc;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 8'h00, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        winc = 1'b0;
        rinc = 1'b0;
        for (int c = 0; c < NCH; c++) mq[c].delete();
        exp_f.delete();
        exp_r.delete();
        exp_wovf = 1'b0;
        exp_rudf = 1'b0;
        #1;
        chk("rst_async_rvalid_r", rvalid_r, 0);
        chk("rst_async_rdata_r", rdata_r, 0);
        chk("rst_async_level_f", level_f, 0);
        chk("rst_async_level_r", level_r, 0);
        chk("rst_async_rempty", rempty_f, 4'hF);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares every output against the model away from the rising edge.
    initial begin
        logic [19:0] e_lvl;
        logic [15:0] e_flg;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                e_lvl[c*5 +: 5] = 5'(mq[c].size());
                e_flg[12+c] = (mq[c].size() == DEP);
                e_flg[8+c]  = (mq[c].size() >= DEP - 1);
                e_flg[4+c]  = (mq[c].size() == 0);
                e_flg[c]    = (mq[c].size() <= 1);
            end
            chk("level_f", level_f, e_lvl);
            chk("level_r", level_r, e_lvl);
            chk("flags_f", {wfull_f, awfull_f, rempty_f, arempty_f}, e_flg);
            chk("flags_r", {wfull_r, awfull_r, rempty_r, arempty_r}, e_flg);
            chk("wovf", {wovf_f, wovf_r}, {exp_wovf, exp_wovf});
            chk("rudf", {rudf_f, rudf_r}, {exp_rudf, exp_rudf});
            chk("rvalid_f", rvalid_f, (mq[rch].size() > 0));
            if (exp_f.size() > 0)
                chk("rdata_f", rdata_f, exp_f.pop_front());
            chk("rvalid_r", rvalid_r, (exp_r.size() > 0));
            if (rvalid_r && exp_r.size() > 0)
                chk("rdata_r", rdata_r, exp_r.pop_front());
        end
    end

    initial begin
        int wp;
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; wch = '0; rch = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t1_rempty", rempty_f, 4'hF);
        chk("t1_arempty", arempty_f, 4'hF);
        chk("t1_wfull", wfull_f, 4'h0);
        chk("t1_level", level_f, 20'h0);
        chk("t1_rvalid", {rvalid_f, rvalid_r}, 2'b00);

        // Fill channel 2 up to and past full.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2, 8'(i), 1'b0, 0);
            if (i == 14) begin
                chk("t2_awfull_15", awfull_f[2], 1);
                chk("t2_wfull_15", wfull_f[2], 0);
            end
        end
        chk("t2_wfull_16", wfull_f[2], 1);
        step(1'b1, 2, 8'h55, 1'b0, 0);
        chk("t2_wovf", wovf_f, 1);
        chk("t2_level2", level_f[14:10], 16);
        chk("t2_others", {level_f[19:15], level_f[9:0]}, 0);

        // Drain channel 2, one read beyond empty.
        for (int i = 0; i < 17; i++) step(1'b0, 0, 8'h00, 1'b1, 2);
        chk("t3_rudf", rudf_f, 1);
        chk("t3_rempty2", rempty_f[2], 1);

        // Pointer wrap on channel 0.
        for (int i = 0; i < 10; i++) step(1'b1, 0, 8'(8'h40 + i), 1'b0, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 8'h00, 1'b1, 0);
        for (int i = 0; i < 16; i++) step(1'b1, 0, 8'(8'h80 + i), 1'b0, 0);
        chk("t4_wfull0", wfull_f[0], 1);
        chk("t4_level0", level_f[4:0], 16);
        for (int i = 0; i < 16; i++) step(1'b0, 0, 8'h00, 1'b1, 0);

        // Simultaneous push/pop at the full and empty boundaries.
        for (int i = 0; i < 16; i++) step(1'b1, 1, 8'(8'hC0 + i), 1'b0, 0);
        step(1'b1, 1, 8'hEE, 1'b1, 1);
        chk("t5_full_wovf", wovf_f, 1);
        chk("t5_full_rudf", rudf_f, 0);
        chk("t5_level1", level_f[9:5], 15);
        step(1'b1, 3, 8'h33, 1'b1, 3);
        chk("t5_empty_rudf", rudf_f, 1);
        chk("t5_empty_wovf", wovf_f, 0);
        chk("t5_level3", level_f[19:15], 1);

        // Registered-read timing and reset mid-stream.
        do_reset();
        step(1'b1, 1, 8'hA5, 1'b0, 0);
        step(1'b0, 0, 8'h00, 1'b1, 1);
        chk("t6_rvalid_r", rvalid_r, 1);
        chk("t6_rdata_r", rdata_r, 8'hA5);
        idle();
        chk("t6_rvalid_r_drop", rvalid_r, 0);
        chk("t6_rdata_r_hold", rdata_r, 8'hA5);
        step(1'b1, 1, 8'h3C, 1'b0, 0);
        step(1'b1, 0, 8'h77, 1'b1, 1);
        chk("t6_rvalid_r_pend", rvalid_r, 1);
        do_reset();

        // Randomised traffic in alternating write-heavy / read-heavy phases.
        for (int ph = 0; ph < 12; ph++) begin
            wp = (ph % 2 == 0) ? 75 : 30;
            for (int n = 0; n < 250; n++) begin
                step($urandom_range(0, 99) < wp, int'($urandom_range(0, 3)),
                     8'($urandom), $urandom_range(0, 99) < (100 - wp),
                     int'($urandom_range(0, 3)));
            end
        end
        idle();
        idle();
        chk("exp_r_drained", exp_r.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
